// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
//   Top-level game sequencer and event arbiter for the player life/money block.
//   Walks through IDLE -> PLAY (levels 1..MAX_LEVEL) -> WIN / OVER, times each
//   level with a one-second prescaler, merges per-source hit requests into a
//   round-robin arbitrated single-cycle hit pulse, and merges damage requests
//   into a single-cycle damage pulse.
//
// Optional feature macro: INVULN_EN
//   defined   : after each damage pulse, damage requests are dropped for
//               INVULN_CYC PLAY cycles
//   undefined : every PLAY cycle with a damage request produces a pulse
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   start      single-cycle start/restart pulse
//   pause      single-cycle pause-toggle pulse
//   fail       life exhausted (from player block)
//   hit_req    per-source hit request pulses   [N_SRC]
//   dmg_req    per-source damage request pulses [N_SRC]
//   state      0 idle, 1..MAX_LEVEL level, 14 win, 15 game over
//   hit        registered single-cycle hit pulse
//   hit_gnt    one-hot granted source, aligned with hit [N_SRC]
//   damage     registered single-cycle damage pulse
//   time_left  seconds remaining in the current level
//   paused     high while paused
// ---------------------------------------------------------------------------
module game_ctrl #(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned LEVEL_SEC  = 30,
  parameter int unsigned MAX_LEVEL  = 9,
  parameter int unsigned INVULN_CYC = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             fail,
  input  logic [N_SRC-1:0] hit_req,
  input  logic [N_SRC-1:0] dmg_req,
  output logic [3:0]       state,
  output logic             hit,
  output logic [N_SRC-1:0] hit_gnt,
  output logic             damage,
  output logic [5:0]       time_left,
  output logic             paused
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = $clog2(N_SRC);

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_WIN  = 4'd14;
  localparam logic [3:0] ST_OVER = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_PAUSE,
    S_OVER,
    S_WIN
  } fsm_t;

  fsm_t             fsm_q;
  logic [3:0]       level_q;
  logic [3:0]       state_q;
  logic             hit_q;
  logic [N_SRC-1:0] gnt_q;
  logic             damage_q;
  logic [5:0]       time_left_q;
  logic             paused_q;
  logic [N_SRC-1:0] pending_q;
  logic [RW-1:0]    rr_q;
  logic [PW-1:0]    presc_q;

`ifdef INVULN_EN
  localparam int unsigned IW = (INVULN_CYC > 1) ? $clog2(INVULN_CYC + 1) : 1;
  logic [IW-1:0]    invuln_q;
`else
  // Window compiled out; the parameter stays so overrides remain legal.
  logic unused_invuln_cyc;
  assign unused_invuln_cyc = |INVULN_CYC;
`endif

  // ------------------------------------------------------------------------
  // Round-robin winner search over pending plus this cycle's requests
  // ------------------------------------------------------------------------
  logic [N_SRC-1:0] cand;
  logic             win_vld;
  logic [RW-1:0]    win_idx;
  logic [N_SRC-1:0] win_oh;
  logic [RW-1:0]    rr_d;
  logic             tick;

  assign cand = pending_q | hit_req;
  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    int unsigned idx;
    win_vld = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      idx = (32'(rr_q) + i) % N_SRC;
      if (!win_vld && cand[idx]) begin
        win_vld     = 1'b1;
        win_idx     = RW'(idx);
        win_oh      = '0;
        win_oh[idx] = 1'b1;
      end
    end
  end

  assign rr_d = (win_idx == RW'(N_SRC - 1)) ? '0 : win_idx + 1'b1;

  // ------------------------------------------------------------------------
  // Sequencer, timer, arbiter and damage path
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      level_q     <= 4'd0;
      state_q     <= ST_IDLE;
      hit_q       <= 1'b0;
      gnt_q       <= '0;
      damage_q    <= 1'b0;
      time_left_q <= 6'(LEVEL_SEC);
      paused_q    <= 1'b0;
      pending_q   <= '0;
      rr_q        <= '0;
      presc_q     <= '0;
`ifdef INVULN_EN
      invuln_q    <= '0;
`endif
    end else begin
      // Pulses are single-cycle unless re-asserted below.
      hit_q    <= 1'b0;
      gnt_q    <= '0;
      damage_q <= 1'b0;

      case (fsm_q)
        S_IDLE: begin
          pending_q <= '0;
          if (start) begin
            fsm_q       <= S_PLAY;
            level_q     <= 4'd1;
            state_q     <= 4'd1;
            time_left_q <= 6'(LEVEL_SEC);
            presc_q     <= '0;
`ifdef INVULN_EN
            invuln_q    <= '0;
`endif
          end
        end

        S_PLAY: begin
          if (fail) begin
            fsm_q     <= S_OVER;
            state_q   <= ST_OVER;
            pending_q <= '0;
          end else if (pause) begin
            // Pause edge: no grant, but this cycle's requests are kept.
            fsm_q     <= S_PAUSE;
            paused_q  <= 1'b1;
            pending_q <= cand;
          end else begin
            if (win_vld) begin
              hit_q     <= 1'b1;
              gnt_q     <= win_oh;
              pending_q <= cand & ~win_oh;
              rr_q      <= rr_d;
            end else begin
              pending_q <= cand;
            end

`ifdef INVULN_EN
            if (invuln_q != '0) begin
              invuln_q <= invuln_q - 1'b1;
            end else if (|dmg_req) begin
              damage_q <= 1'b1;
              invuln_q <= IW'(INVULN_CYC);
            end
`else
            if (|dmg_req) begin
              damage_q <= 1'b1;
            end
`endif

            if (tick) begin
              presc_q <= '0;
              if (time_left_q == 6'd1) begin
                if (level_q < 4'(MAX_LEVEL)) begin
                  level_q     <= level_q + 4'd1;
                  state_q     <= level_q + 4'd1;
                  time_left_q <= 6'(LEVEL_SEC);
                end else begin
                  // Entering WIN overrides any pulse decided above.
                  fsm_q     <= S_WIN;
                  state_q   <= ST_WIN;
                  pending_q <= '0;
                  hit_q     <= 1'b0;
                  gnt_q     <= '0;
                  damage_q  <= 1'b0;
                end
              end else begin
                time_left_q <= time_left_q - 6'd1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
        end

        S_PAUSE: begin
          // Timer, prescaler and invulnerability are frozen; dmg_req dropped.
          pending_q <= cand;
          if (pause) begin
            // The resume edge already arbitrates, so a request latched while
            // paused is granted in the first cycle back in PLAY.
            fsm_q    <= S_PLAY;
            paused_q <= 1'b0;
            if (win_vld) begin
              hit_q     <= 1'b1;
              gnt_q     <= win_oh;
              pending_q <= cand & ~win_oh;
              rr_q      <= rr_d;
            end
          end
        end

        S_OVER, S_WIN: begin
          pending_q <= '0;
          if (start) begin
            fsm_q       <= S_IDLE;
            state_q     <= ST_IDLE;
            level_q     <= 4'd0;
            time_left_q <= 6'(LEVEL_SEC);
          end
        end

        default: begin
          fsm_q     <= S_IDLE;
          state_q   <= ST_IDLE;
          pending_q <= '0;
          paused_q  <= 1'b0;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign hit       = hit_q;
  assign hit_gnt   = gnt_q;
  assign damage    = damage_q;
  assign time_left = time_left_q;
  assign paused    = paused_q;

endmodule
